// File: rtl/avalon_st_rl_adapter.sv
`default_nettype none
// ============================================================================
// Module   : avalon_st_rl_adapter
// Purpose  : Avalon-ST ready-latency adapter with a show-ahead buffer FIFO
//            and sticky overflow / saturating drop accounting.
// Revision : 1.0  initial release
// ============================================================================
module avalon_st_rl_adapter #(
   parameter int DATA_WIDTH        = 32,
   parameter int IN_READY_LATENCY  = 0,
   parameter int OUT_READY_LATENCY = 1,
   parameter int FIFO_DEPTH        = 8,
   parameter int CNT_WIDTH         = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [DATA_WIDTH-1:0]         out_data,
   input  logic                          out_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fill_level,
   output logic                          overflow,
   input  logic                          clear_overflow,
   output logic [CNT_WIDTH-1:0]          drop_count
);

   localparam int c_addr_w = $clog2(FIFO_DEPTH);
   localparam int c_fill_w = c_addr_w + 1;
   localparam logic [c_fill_w-1:0] c_depth   = c_fill_w'(FIFO_DEPTH);
   localparam logic [c_fill_w-1:0] c_in_need = c_fill_w'(IN_READY_LATENCY + 1);

   generate
      if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) ||
          (FIFO_DEPTH < IN_READY_LATENCY + 1)) begin : g_bad_cfg
         $error("avalon_st_rl_adapter: FIFO_DEPTH must be a power of two >= max(2, IN_READY_LATENCY+1)");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [c_addr_w-1:0]   r_wr_ptr;
   logic [c_addr_w-1:0]   r_rd_ptr;
   logic [c_fill_w-1:0]   r_fill;
   logic                  r_overflow;
   logic [CNT_WIDTH-1:0]  r_drop_count;

   logic                  w_full;
   logic                  w_empty;
   logic [c_fill_w-1:0]   w_free;
   logic                  w_gate;
   logic                  w_valid;
   logic                  w_rd_en;
   logic                  w_wr_en;
   logic                  w_drop;

   assign w_full  = (r_fill == c_depth);
   assign w_empty = (r_fill == '0);
   assign w_free  = c_depth - r_fill;

   // Effective ready: raw out_ready at latency 0, else out_ready delayed
   // through a reset-cleared shift register.
   generate
      if (OUT_READY_LATENCY == 0) begin : g_rl0
         assign w_gate  = 1'b1;
         assign w_rd_en = w_valid & out_ready;
      end else begin : g_rl_pipe
         logic [OUT_READY_LATENCY-1:0] r_rdy_pipe;
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_rdy_pipe <= '0;
            end else begin
               r_rdy_pipe[0] <= out_ready;
               for (int i = 1; i < OUT_READY_LATENCY; i++) begin
                  r_rdy_pipe[i] <= r_rdy_pipe[i-1];
               end
            end
         end
         assign w_gate  = r_rdy_pipe[OUT_READY_LATENCY-1];
         assign w_rd_en = w_valid;
      end
   endgenerate

   assign w_valid = ~reset & ~w_empty & w_gate;
   assign w_wr_en = ~reset & in_valid & (~w_full | w_rd_en);
   assign w_drop  = ~reset & in_valid & ~w_wr_en;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_addr_w'(1);
         if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_addr_w'(1);
         case ({w_wr_en, w_rd_en})
            2'b10:   r_fill <= r_fill + c_fill_w'(1);
            2'b01:   r_fill <= r_fill - c_fill_w'(1);
            default: r_fill <= r_fill;
         endcase
      end
   end

   // A clear wins over a drop in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (clear_overflow) begin
         r_overflow   <= 1'b0;
         r_drop_count <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_count != '1) r_drop_count <= r_drop_count + CNT_WIDTH'(1);
      end
   end

   assign in_ready   = ~reset & (w_free >= c_in_need);
   assign out_valid  = w_valid;
   assign out_data   = r_mem[r_rd_ptr];
   assign fill_level = r_fill;
   assign overflow   = r_overflow;
   assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_rl_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_st_rl_adapter
// Purpose  : Directed self-checking bench for avalon_st_rl_adapter.
// Revision : 1.0  initial release
// ============================================================================
module tb_avalon_st_rl_adapter;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   // Main instance: IN_RL=0, OUT_RL=1, DEPTH=8
   logic        in_valid, in_ready, out_valid, out_ready, overflow, clear_overflow;
   logic [31:0] in_data, out_data;
   logic [3:0]  fill_level;
   logic [15:0] drop_count;

   // Second instance: IN_RL=2, OUT_RL=1, DEPTH=4
   logic        in_valid_b, in_ready_b, out_valid_b, overflow_b;
   logic [31:0] in_data_b, out_data_b;
   logic [2:0]  fill_level_b;
   logic [15:0] drop_count_b;

   avalon_st_rl_adapter #(
      .DATA_WIDTH(32), .IN_READY_LATENCY(0), .OUT_READY_LATENCY(1),
      .FIFO_DEPTH(8), .CNT_WIDTH(16)
   ) u_dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .fill_level(fill_level), .overflow(overflow),
      .clear_overflow(clear_overflow), .drop_count(drop_count)
   );

   avalon_st_rl_adapter #(
      .DATA_WIDTH(32), .IN_READY_LATENCY(2), .OUT_READY_LATENCY(1),
      .FIFO_DEPTH(4), .CNT_WIDTH(16)
   ) u_dut_b (
      .clk(clk), .reset(reset),
      .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(1'b0),
      .fill_level(fill_level_b), .overflow(overflow_b),
      .clear_overflow(1'b0), .drop_count(drop_count_b)
   );

   int          n_chk = 0;
   int          n_err = 0;
   int          n_out = 0;
   logic [31:0] exp_q [$];
   logic        grant_b [0:15];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called just after a rising edge: checks any beat leaving at the next
   // edge, drives the next input beat, then advances one cycle.
   task automatic step(input logic v, input logic [31:0] d, input logic acc);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("stale_beat", 32'(out_valid), 32'd0);
         end else begin
            check("order", out_data, exp_q.pop_front());
            n_out++;
         end
      end
      in_valid = v;
      in_data  = d;
      if (acc) exp_q.push_back(d);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clear_overflow = 1'b0;
      in_valid_b = 1'b0; in_data_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_fill", 32'(fill_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_drops", 32'(drop_count), 32'd0);
      reset = 1'b0;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // IN_RL=2, DEPTH=4 source honours the latency, sink stalled
      for (int t = 0; t < 12; t++) begin
         grant_b[t] = in_ready_b;
         in_valid_b = (t >= 2) ? grant_b[t-2] : 1'b0;
         in_data_b  = 32'(t);
         check("rl2_in_ready", 32'(in_ready_b), 32'(fill_level_b < 3'd2));
         check("rl2_fill_max", 32'(fill_level_b > 3'd4), 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid_b = 1'b0;
      check("rl2_fill_final", 32'(fill_level_b), 32'd4);
      check("rl2_no_overflow", 32'(overflow_b), 32'd0);

      // Streaming 0x1..0x20 with out_ready held high
      out_ready = 1'b1;
      repeat (2) step(1'b0, 32'd0, 1'b0);
      check("first_idle", 32'(out_valid), 32'd0);
      step(1'b1, 32'd1, 1'b1);
      check("first_latency", 32'(out_valid), 32'd1);
      for (int k = 2; k <= 32; k++) step(1'b1, 32'(k), 1'b1);
      repeat (3) step(1'b0, 32'd0, 1'b0);
      check("stream_count", 32'(n_out), 32'd32);
      check("stream_drops", 32'(drop_count), 32'd0);
      check("stream_fill", 32'(fill_level), 32'd0);

      // Sink stall for 10 cycles, source honours in_ready
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         automatic logic g = in_ready;
         step(g, 32'h100 + 32'(i), g);
      end
      in_valid = 1'b0;
      check("stall_fill", 32'(fill_level), 32'd8);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      check("resume_wait", 32'(out_valid), 32'd0);
      step(1'b0, 32'd0, 1'b0);
      check("resume_1cyc", 32'(out_valid), 32'd1);
      check("resume_fill", 32'(fill_level), 32'd8);
      // Write into a full FIFO together with a read
      step(1'b1, 32'h1FF, 1'b1);
      check("full_rw_fill", 32'(fill_level), 32'd8);
      check("full_rw_nodrop", 32'(drop_count), 32'd0);
      check("full_rw_noovf", 32'(overflow), 32'd0);
      repeat (10) step(1'b0, 32'd0, 1'b0);
      check("stall_drained", 32'(exp_q.size()), 32'd0);
      check("stall_count", 32'(n_out), 32'd41);

      // Source ignores in_ready: 12 beats into 8 entries
      out_ready = 1'b0;
      step(1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 12; i++) step(1'b1, 32'h200 + 32'(i), i < 8);
      in_valid = 1'b0;
      check("ovf_fill", 32'(fill_level), 32'd8);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_drops", 32'(drop_count), 32'd4);
      clear_overflow = 1'b1;
      step(1'b0, 32'd0, 1'b0);
      clear_overflow = 1'b0;
      check("clr_flag", 32'(overflow), 32'd0);
      check("clr_drops", 32'(drop_count), 32'd0);
      clear_overflow = 1'b1;
      step(1'b1, 32'h2FF, 1'b0);
      clear_overflow = 1'b0;
      in_valid = 1'b0;
      check("clr_prio_flag", 32'(overflow), 32'd0);
      check("clr_prio_drops", 32'(drop_count), 32'd0);
      out_ready = 1'b1;
      repeat (11) step(1'b0, 32'd0, 1'b0);
      check("ovf_drained", 32'(exp_q.size()), 32'd0);
      check("ovf_count", 32'(n_out), 32'd49);

      // Reset with 5 beats buffered
      out_ready = 1'b0;
      step(1'b0, 32'd0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 32'h300 + 32'(i), 1'b1);
      in_valid = 1'b0;
      check("pre_rst_fill", 32'(fill_level), 32'd5);
      out_ready = 1'b1;
      step(1'b0, 32'd0, 1'b0);
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 32'd0);
      check("async_rst_in_ready", 32'(in_ready), 32'd0);
      check("async_rst_fill", 32'(fill_level), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      repeat (4) step(1'b0, 32'd0, 1'b0);
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
      check("post_rst_fill", 32'(fill_level), 32'd0);
      step(1'b1, 32'h400, 1'b1);
      repeat (3) step(1'b0, 32'd0, 1'b0);
      check("post_rst_count", 32'(n_out), 32'd50);
      check("post_rst_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
